mask_rle_reader: RTL

// Read side of the 1-bit filtered foreground frame buffer written by the blob

---
 rtl/mask_rle_reader.sv | 95 +++++++++
 1 files changed

// File: rtl/mask_rle_reader.sv
// mask_rle_reader: raster-scans a 1-bit mask frame from a registered-read RAM and streams per-row run-length words.
module mask_rle_reader #(
  parameter int H_IMG_RES = 640,
  parameter int V_IMG_RES = 480,
  parameter int ADDR_W    = 19,
  parameter int RUN_W     = 16
) (
  input  logic              app_clk,
  input  logic              app_rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rd_data,
  output logic              rle_valid,
  input  logic              rle_ready,
  output logic [RUN_W:0]    rle_data,
  output logic              rle_eol,
  output logic              rle_eof
);
  localparam int XW = $clog2(H_IMG_RES + 1);
  localparam int YW = $clog2(V_IMG_RES);
  localparam logic [RUN_W-1:0] RUN_MAX = '1;
  typedef enum logic [1:0] {IDLE, SCAN, ROW_END, LAST} state_t;
  state_t state, state_n;
  logic [XW-1:0] px;
  logic [YW-1:0] py;
  logic [ADDR_W-1:0] base;
  logic cur_pix;
  logic [RUN_W-1:0] cur_len;
  logic loadable, emit, stall, last_row, hs_eof;
  assign busy     = state != IDLE;
  assign loadable = !rle_valid || rle_ready;
  assign last_row = py == YW'(V_IMG_RES - 1);
  assign hs_eof   = rle_valid && rle_ready && rle_eof;
  always_comb begin
    emit = (state == SCAN) ? (cur_len != '0 && (mem_rd_data != cur_pix || cur_len == RUN_MAX))
                           : (state == ROW_END);
    stall = emit && !loadable;
    state_n = state;
    case (state)
      IDLE:    state_n = start ? SCAN : IDLE;
      SCAN:    state_n = (!stall && px == XW'(H_IMG_RES - 1)) ? ROW_END : SCAN;
      ROW_END: state_n = stall ? ROW_END : (last_row ? LAST : SCAN);
      LAST:    state_n = hs_eof ? IDLE : LAST;
      default: state_n = IDLE;
    endcase
    // a stalled pixel re-presents its own address so the RAM keeps returning it
    mem_addr = (state == SCAN) ? base + ADDR_W'(px) + ADDR_W'(!stall)
             : (state == ROW_END && !last_row) ? base + ADDR_W'(H_IMG_RES) : '0;
  end
  always_ff @(posedge app_clk) begin
    if (app_rst) begin
      state     <= IDLE;
      px        <= '0;
      py        <= '0;
      base      <= '0;
      cur_pix   <= 1'b0;
      cur_len   <= '0;
      done      <= 1'b0;
      rle_valid <= 1'b0;
      rle_data  <= '0;
      rle_eol   <= 1'b0;
      rle_eof   <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state == LAST && hs_eof;
      if (state == IDLE && start) begin
        px      <= '0;
        py      <= '0;
        base    <= '0;
        cur_len <= '0;
      end
      if (state == SCAN && !stall) begin
        px      <= px + 1'b1;
        cur_pix <= mem_rd_data;
        cur_len <= (emit || cur_len == '0) ? RUN_W'(1) : cur_len + 1'b1;
      end
      if (state == ROW_END && !stall) begin
        px      <= '0;
        py      <= py + 1'b1;
        base    <= base + ADDR_W'(H_IMG_RES);
        cur_len <= '0;
      end
      if (emit && !stall) begin
        rle_valid <= 1'b1;
        rle_data  <= {cur_pix, cur_len};
        rle_eol   <= state == ROW_END;
        rle_eof   <= state == ROW_END && last_row;
      end else if (rle_ready) begin
        rle_valid <= 1'b0;
      end
    end
  end
endmodule
